// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled from baudClock, one-byte holding buffer,
// framing/overrun status on a simple memory bus. Define UART_RX_MAJORITY_EN for 2-of-3 sampling.
module uart_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        baudClock,
  input  logic        serialIn,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_reg;
  logic [1:0]  rx_sync_reg;
  logic [1:0]  baud_sync_reg;
  logic        baud_prev_reg;
  logic [3:0]  tick_count_reg;
  logic [2:0]  bit_index_reg;
  logic [7:0]  shifter_reg;
  logic [7:0]  buffer_reg;
  logic        data_valid_reg;
  logic        overrun_reg;
  logic        framing_error_reg;
  logic        rdy_reg;

  logic tick, rx, sample_now, sample_bit;
  logic acc, sel_status, data_read, status_w1c, buffer_free;
  logic unused_bits;

  assign tick = baud_sync_reg[1] & ~baud_prev_reg;
  assign rx   = rx_sync_reg[1];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SAMPLE_POS = 4'd9;
  logic [1:0] early_reg;

  // Samples at positions 7 and 8; the third vote is the live value at position 9.
  always_ff @(posedge clk) begin
    if (reset) begin
      early_reg <= 2'b00;
    end else if (tick && state_reg != IDLE) begin
      if (tick_count_reg == 4'd7) early_reg[0] <= rx;
      if (tick_count_reg == 4'd8) early_reg[1] <= rx;
    end
  end
  assign sample_bit = (early_reg[0] & early_reg[1]) | (early_reg[0] & rx) | (early_reg[1] & rx);
`else
  localparam logic [3:0] SAMPLE_POS = 4'd8;
  assign sample_bit = rx;
`endif

  assign sample_now  = tick && (tick_count_reg == SAMPLE_POS);
  assign acc         = mem_valid & enable & ~rdy_reg;
  assign sel_status  = mem_addr[2];
  assign data_read   = acc & ~sel_status & (mem_wstrb == 4'b0000);
  assign status_w1c  = acc & sel_status & mem_wstrb[0];
  // A DATA read landing with the stop sample frees the buffer for the incoming byte.
  assign buffer_free = ~data_valid_reg | data_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      rx_sync_reg       <= 2'b11;
      baud_sync_reg     <= 2'b00;
      baud_prev_reg     <= 1'b0;
      tick_count_reg    <= 4'd0;
      bit_index_reg     <= 3'd0;
      shifter_reg       <= 8'd0;
      buffer_reg        <= 8'd0;
      data_valid_reg    <= 1'b0;
      overrun_reg       <= 1'b0;
      framing_error_reg <= 1'b0;
      rdy_reg           <= 1'b0;
    end else begin
      rx_sync_reg   <= {rx_sync_reg[0], serialIn};
      baud_sync_reg <= {baud_sync_reg[0], baudClock};
      baud_prev_reg <= baud_sync_reg[1];
      rdy_reg       <= mem_valid & enable;

      if (data_read) data_valid_reg <= 1'b0;
      if (status_w1c) begin
        if (mem_wdata[1]) overrun_reg <= 1'b0;
        if (mem_wdata[2]) framing_error_reg <= 1'b0;
      end

      // Receiver updates come last so a load or error set overrides a same-cycle clear.
      if (tick) begin
        if (state_reg != IDLE) tick_count_reg <= tick_count_reg + 4'd1;
        case (state_reg)
          IDLE: begin
            if (!rx) begin
              state_reg      <= START;
              tick_count_reg <= 4'd0;
            end
          end
          START: begin
            if (sample_now && sample_bit) begin
              state_reg <= IDLE;
            end else if (tick_count_reg == 4'd15) begin
              state_reg     <= DATA;
              bit_index_reg <= 3'd0;
            end
          end
          DATA: begin
            if (sample_now) shifter_reg <= {sample_bit, shifter_reg[7:1]};
            if (tick_count_reg == 4'd15) begin
              bit_index_reg <= bit_index_reg + 3'd1;
              if (bit_index_reg == 3'd7) state_reg <= STOP;
            end
          end
          STOP: begin
            if (sample_now) begin
              state_reg <= IDLE;
              if (!sample_bit) begin
                framing_error_reg <= 1'b1;
              end else if (buffer_free) begin
                buffer_reg     <= shifter_reg;
                data_valid_reg <= 1'b1;
              end else begin
                overrun_reg <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign mem_ready = enable & rdy_reg;
  assign mem_rdata = !enable   ? 32'd0 :
                     sel_status ? {29'd0, framing_error_reg, overrun_reg, data_valid_reg} :
                                  {24'd0, buffer_reg};
  assign irq = data_valid_reg;

  assign unused_bits = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:3], mem_wdata[0]};
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, hand-written corner sequences,
// and randomized frames checked against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        reset, enable, mem_valid, mem_ready, mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic        baudClock, serialIn, irq;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .baudClock(baudClock), .serialIn(serialIn), .irq(irq)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_IDX = 10;
`else
  localparam int DECIDE_IDX = 9;
`endif

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One oversampling tick; line value is applied well before the baud edge.
  task automatic baud_tick(input logic line, input bit read_at_edge);
    @(negedge clk); serialIn = line; baudClock = 1'b0;
    repeat (3) @(negedge clk);
    baudClock = 1'b1;
    repeat (2) @(negedge clk);
    if (read_at_edge) begin
      enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'h0;
    end
    @(negedge clk);
    if (read_at_edge) begin
      mem_valid = 1'b0; enable = 1'b0;
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) baud_tick(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int read_tick);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    $display("frame data=0x%02h stop=%0b", b, stop);
    for (int c = 0; c < 10; c++)
      for (int t = 0; t < 16; t++)
        baud_tick(bits[c], (c == 9) && (t == read_tick));
    if (!stop) idle_ticks(24);
  endtask

  task automatic bus(input logic sel_status, input logic [3:0] wstrb, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    int lat;
    @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1; mem_addr = sel_status ? 32'h4 : 32'h0;
    mem_wstrb = wstrb; mem_wdata = wdata;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_ready) break;
    end
    rdata = mem_rdata;
    check("ready_lat", lat, 32'd1);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    check("ready_fall", {31'd0, mem_ready}, 32'd0);
    enable = 1'b0;
    $display("bus %s wstrb=%h wdata=0x%08h rdata=0x%08h", sel_status ? "STATUS" : "DATA", wstrb, wdata, rdata);
  endtask

  typedef enum logic [2:0] {OP_FRAME, OP_RD_DATA, OP_RD_STAT, OP_WR_STAT, OP_WR_DATA, OP_IRQ, OP_GLITCH, OP_GATE} op_t;
  typedef struct {
    op_t         op;
    logic [7:0]  val;
    logic        stop;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  // Frame-level reference state
  logic [7:0] m_buf;
  logic       m_dv, m_ovr, m_fe;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    reset = 1'b1; enable = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_wstrb = 4'h0; mem_wdata = 32'h0; mem_addr = 32'h0;
    baudClock = 1'b0; serialIn = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    enable = 1'b1; mem_addr = 32'h0; #1;
    check("rst_data", mem_rdata, 32'd0);
    mem_addr = 32'h4; #1;
    check("rst_status", mem_rdata, 32'd0);
    enable = 1'b0;

    vecs.push_back('{OP_FRAME,   8'h55, 1'b1, 32'h0});
    vecs.push_back('{OP_IRQ,     8'h00, 1'b0, 32'h1});
    vecs.push_back('{OP_GATE,    8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_RD_DATA, 8'h00, 1'b0, 32'h55});
    vecs.push_back('{OP_IRQ,     8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_FRAME,   8'hA3, 1'b1, 32'h0});
    vecs.push_back('{OP_RD_DATA, 8'h00, 1'b0, 32'hA3});
    vecs.push_back('{OP_FRAME,   8'h0F, 1'b1, 32'h0});
    vecs.push_back('{OP_RD_DATA, 8'h00, 1'b0, 32'h0F});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_GLITCH,  8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_IRQ,     8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_FRAME,   8'h81, 1'b0, 32'h0});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h4});
    vecs.push_back('{OP_IRQ,     8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_WR_STAT, 8'h04, 1'b0, 32'h0});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h0});
    vecs.push_back('{OP_FRAME,   8'h11, 1'b1, 32'h0});
    vecs.push_back('{OP_FRAME,   8'h22, 1'b1, 32'h0});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h3});
    vecs.push_back('{OP_WR_STAT, 8'h02, 1'b0, 32'h0});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h1});
    vecs.push_back('{OP_WR_DATA, 8'hFF, 1'b0, 32'h0});
    vecs.push_back('{OP_WR_STAT, 8'h01, 1'b0, 32'h0});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h1});
    vecs.push_back('{OP_RD_DATA, 8'h00, 1'b0, 32'h11});
    vecs.push_back('{OP_RD_STAT, 8'h00, 1'b0, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_FRAME:   send_frame(vecs[i].val, vecs[i].stop, -1);
        OP_RD_DATA: begin bus(1'b0, 4'h0, 32'h0, rd); check($sformatf("vec%0d_data", i), rd, vecs[i].exp); end
        OP_RD_STAT: begin bus(1'b1, 4'h0, 32'h0, rd); check($sformatf("vec%0d_status", i), rd, vecs[i].exp); end
        OP_WR_STAT: bus(1'b1, 4'h1, {24'd0, vecs[i].val}, rd);
        OP_WR_DATA: bus(1'b0, 4'hF, {24'd0, vecs[i].val}, rd);
        OP_IRQ:     check($sformatf("vec%0d_irq", i), {31'd0, irq}, vecs[i].exp);
        OP_GLITCH: begin
          for (int t = 0; t < 4; t++) baud_tick(1'b0, 1'b0);
          idle_ticks(20);
        end
        OP_GATE: begin
          @(negedge clk); enable = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0;
          repeat (2) @(negedge clk);
          check($sformatf("vec%0d_gate_ready", i), {31'd0, mem_ready}, 32'd0);
          check($sformatf("vec%0d_gate_rdata", i), mem_rdata, 32'd0);
          mem_valid = 1'b0;
        end
        default: ;
      endcase
    end

    // DATA read coinciding with the stop-sample load while the buffer is full
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'h96, 1'b1, DECIDE_IDX);
    bus(1'b1, 4'h0, 32'h0, rd); check("collide_status", rd, 32'h1);
    bus(1'b0, 4'h0, 32'h0, rd); check("collide_data", rd, 32'h96);
    bus(1'b1, 4'h0, 32'h0, rd); check("collide_status2", rd, 32'h0);

    // Reset in the middle of data bit 4, then a clean frame
    send_frame(8'h5A, 1'b1, -1);
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'hC6, 1'b0};
      for (int c = 0; c < 5; c++)
        for (int t = 0; t < 16; t++) baud_tick(bits[c], 1'b0);
      for (int t = 0; t < 4; t++) baud_tick(bits[5], 1'b0);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_ready", {31'd0, mem_ready}, 32'd0);
    enable = 1'b1; mem_addr = 32'h0; #1;
    check("midrst_data", mem_rdata, 32'd0);
    mem_addr = 32'h4; #1;
    check("midrst_status", mem_rdata, 32'd0);
    enable = 1'b0;
    idle_ticks(20);
    send_frame(8'hC6, 1'b1, -1);
    bus(1'b1, 4'h0, 32'h0, rd); check("post_rst_status", rd, 32'h1);
    bus(1'b0, 4'h0, 32'h0, rd); check("post_rst_data", rd, 32'hC6);

    // Randomized frames against the reference model
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_buf = 8'h00; m_dv = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      logic       s;
      logic [2:0] w;
      int         act;
      b = 8'($urandom);
      s = ($urandom_range(0, 4) != 0);
      send_frame(b, s, -1);
      if (!s) m_fe = 1'b1;
      else if (!m_dv) begin m_buf = b; m_dv = 1'b1; end
      else m_ovr = 1'b1;
      if (s) idle_ticks($urandom_range(0, 2));
      act = $urandom_range(0, 3);
      if (act == 0) begin
        bus(1'b0, 4'h0, 32'h0, rd);
        check($sformatf("rand%0d_data", n), rd, {24'd0, m_buf});
        m_dv = 1'b0;
      end else if (act == 1) begin
        bus(1'b1, 4'h0, 32'h0, rd);
        check($sformatf("rand%0d_status", n), rd, {29'd0, m_fe, m_ovr, m_dv});
      end else if (act == 2) begin
        w = 3'($urandom_range(0, 7));
        bus(1'b1, 4'h1, {29'd0, w}, rd);
        if (w[1]) m_ovr = 1'b0;
        if (w[2]) m_fe = 1'b0;
        bus(1'b1, 4'h0, 32'h0, rd);
        check($sformatf("rand%0d_w1c", n), rd, {29'd0, m_fe, m_ovr, m_dv});
      end
      check($sformatf("rand%0d_irq", n), {31'd0, irq}, {31'd0, m_dv});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
